rr_arb4: RTL and testbench



---
 rtl/rr_arb4_pkg.sv | 49 ++++
 rtl/rr_arb4_d2to4.sv | 27 ++
 rtl/rr_arb4.sv | 127 ++++++++++++
 tb/tb_rr_arb4.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_arb4_pkg.sv
// ---------------------------------------------------------------------------
// rr_arb4_pkg
//
// Shared definitions for the four-way round-robin arbiter slice.
//
// Contents:
//   ID_W             width of an owner / requester index (2)
//   N_REQ            number of requesters (4)
//   DEFAULT_MAX_HOLD default number of GRANT cycles before forced release
//   DEFAULT_CW       default width of the hold counter
//   arb_state_t      arbiter state encoding (IDLE=0, GRANT=1)
//   pick_winner()    rotating-priority search helper
// ---------------------------------------------------------------------------
package rr_arb4_pkg;

    localparam int ID_W             = 2;
    localparam int N_REQ            = 4;
    localparam int DEFAULT_MAX_HOLD = 15;
    localparam int DEFAULT_CW       = 4;

    // IDLE means nobody owns the resource; GRANT means gnt_id owns it.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

    // Rotating-priority search. The index after ptr has the highest priority
    // and ptr itself the lowest, so the last owner goes to the back of the
    // line. The loop walks from lowest to highest priority and overwrites
    // the result on every hit, so the final value is the highest-priority
    // requester without needing an early exit. When req is all zero the
    // result is ptr and the caller is expected to ignore it.
    function automatic logic [ID_W-1:0] pick_winner(
        input logic [N_REQ-1:0] req,
        input logic [ID_W-1:0]  ptr
    );
        logic [ID_W-1:0] idx;
        logic [ID_W-1:0] win;
        win = ptr;
        for (int i = N_REQ; i >= 1; i--) begin
            idx = ptr + ID_W'(i);
            if (req[idx]) begin
                win = idx;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/rr_arb4_d2to4.sv
// ---------------------------------------------------------------------------
// d2to4
//
// Shared 2-to-4 decoder with enable. Exactly one output bit is high when the
// enable is high; all outputs are low otherwise.
//
// Ports:
//   a  input  [1:0]  select index
//   e  input         enable
//   y  output [3:0]  one-hot decode of a, or zero when e is low
// ---------------------------------------------------------------------------
module d2to4 (
    input  logic [1:0] a,
    input  logic       e,
    output logic [3:0] y
);

    // Plain decode: start from all-zero and light the selected bit only
    // while enabled.
    always_comb begin
        y = 4'b0000;
        if (e) begin
            y[a] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_arb4.sv
// ---------------------------------------------------------------------------
// rr_arb4
//
// Four-requester round-robin arbiter. One requester at a time owns a shared
// resource. Ownership ends when the owner signals done, drops its request,
// or has held the resource for MAX_HOLD cycles. In the hold-limit case a
// one-cycle timeout pulse is raised. The grant vector is decoded from
// registered state only, so there is no combinational path from req to gnt.
//
// Parameters:
//   MAX_HOLD  GRANT cycles per ownership before forced release (1..2^CW-1)
//   CW        hold counter width
//
// Ports:
//   clk      input         rising-edge clock
//   rst      input         synchronous active-high reset
//   req      input  [3:0]  request vector, bit i belongs to requester i
//   done     input         owner finished (only looked at in GRANT)
//   gnt      output [3:0]  one-hot grant, decoded from gnt_id and busy
//   gnt_id   output [1:0]  current or most recent owner
//   busy     output        resource is currently granted
//   timeout  output        one-cycle pulse after a hold-limit revocation
// ---------------------------------------------------------------------------
module rr_arb4
    import rr_arb4_pkg::*;
#(
    parameter int MAX_HOLD = DEFAULT_MAX_HOLD,
    parameter int CW       = DEFAULT_CW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             busy,
    output logic             timeout
);

    arb_state_t       state;
    logic [ID_W-1:0]  ptr;
    logic [CW-1:0]    cnt;

    logic             owner_withdrew;
    logic             hold_expired;
    logic             release_now;
    logic [ID_W-1:0]  search_ptr;
    logic [ID_W-1:0]  winner;
    logic             any_req;

    localparam logic [CW-1:0] HOLD_LIMIT = CW'(MAX_HOLD);
    localparam logic [CW-1:0] CNT_MAX    = {CW{1'b1}};

    // Work out whether the current ownership ends at this edge. Any of the
    // three causes is enough; they only matter while in GRANT.
    always_comb begin
        owner_withdrew = ~req[gnt_id];
        hold_expired   = (cnt == HOLD_LIMIT);
        release_now    = (state == ST_GRANT) &&
                         (done || owner_withdrew || hold_expired);
    end

    // Choose the next owner. At a release edge the pointer is about to
    // become the outgoing owner, and the search has to see that new value
    // in the same cycle so the handoff needs no idle bubble. The outgoing
    // owner is searched last, so it is only re-granted when nobody else
    // is asking.
    always_comb begin
        search_ptr = release_now ? gnt_id : ptr;
        winner     = pick_winner(req, search_ptr);
        any_req    = |req;
    end

    // Main FSM with all registered outputs. timeout is cleared every cycle
    // and set only on a release caused purely by the hold limit; done or a
    // withdrawn request on the same edge counts as a normal release. In
    // IDLE, done is deliberately ignored and the pointer keeps the last
    // owner so fairness carries across idle periods.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            gnt_id  <= '0;
            ptr     <= ID_W'(N_REQ - 1);
            cnt     <= '0;
            timeout <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        state  <= ST_GRANT;
                        gnt_id <= winner;
                        cnt    <= CW'(1);
                    end
                end
                ST_GRANT: begin
                    if (release_now) begin
                        ptr     <= gnt_id;
                        timeout <= hold_expired && !done && !owner_withdrew;
                        if (any_req) begin
                            gnt_id <= winner;
                            cnt    <= CW'(1);
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = (state == ST_GRANT);

    // The grant vector comes straight out of the shared decoder, fed only
    // by registers.
    d2to4 u_gnt_dec (
        .a (gnt_id),
        .e (busy),
        .y (gnt)
    );

endmodule

// File: tb/tb_rr_arb4.sv
// ---------------------------------------------------------------------------
// tb_rr_arb4
//
// Self-checking bench for rr_arb4. A behavioural model tracks who should
// own the resource using plain integers and modulo arithmetic, and a
// compare process checks every DUT output against it on each falling
// edge. Directed sequences carry hand-computed literal expectations, then
// a randomized phase exercises mixed traffic, done pulses and resets.
// ---------------------------------------------------------------------------
module tb_rr_arb4;

    localparam int MAX_HOLD = 15;
    localparam int CW       = 4;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic       timeout;

    int tests_run;
    int tests_failed;

    rr_arb4 #(
        .MAX_HOLD (MAX_HOLD),
        .CW       (CW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .timeout (timeout)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison helper; every check in the bench goes through here.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h",
                     name, $time, actual, expected);
        end
    endtask

    // -----------------------------------------------------------------------
    // Behavioural model: owner number, last owner, cycles held so far.
    // -----------------------------------------------------------------------
    bit m_valid;
    bit m_busy;
    int m_owner;
    int m_last;
    int m_held;
    bit m_timeout;

    // First requester found walking forward from the one after 'last';
    // -1 when nobody is requesting.
    function automatic int nextOwner(input logic [3:0] r, input int last);
        for (int k = 1; k <= 4; k++) begin
            if (r[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    // Advance the model by one clock using the inputs present at the edge.
    always @(posedge clk) begin
        int  w;
        bit  by_done;
        bit  by_withdraw;
        bit  by_limit;
        if (rst) begin
            m_valid   = 1'b1;
            m_busy    = 1'b0;
            m_owner   = 0;
            m_last    = 3;
            m_held    = 0;
            m_timeout = 1'b0;
        end else if (m_valid) begin
            m_timeout = 1'b0;
            if (!m_busy) begin
                w = nextOwner(req, m_last);
                if (w >= 0) begin
                    m_busy  = 1'b1;
                    m_owner = w;
                    m_held  = 1;
                end
            end else begin
                by_done     = done;
                by_withdraw = !req[m_owner];
                by_limit    = (m_held == MAX_HOLD);
                if (by_done || by_withdraw || by_limit) begin
                    m_timeout = by_limit && !by_done && !by_withdraw;
                    m_last    = m_owner;
                    w = nextOwner(req, m_last);
                    if (w >= 0) begin
                        m_owner = w;
                        m_held  = 1;
                    end else begin
                        m_busy = 1'b0;
                    end
                end else begin
                    m_held = m_held + 1;
                end
            end
        end
    end

    // Compare every output against the model on each falling edge once
    // the model has seen a reset.
    always @(negedge clk) begin
        if (m_valid) begin
            checkOutput("gnt",     {28'd0, gnt},
                        m_busy ? (32'd1 << m_owner) : 32'd0);
            checkOutput("gnt_id",  {30'd0, gnt_id}, 32'(m_owner));
            checkOutput("busy",    {31'd0, busy},    {31'd0, m_busy});
            checkOutput("timeout", {31'd0, timeout}, {31'd0, m_timeout});
        end
    end

    // Drive one cycle of inputs and return just after the following falling
    // edge, where the outputs reflect the edge that sampled these inputs.
    task automatic applyStimulus(input logic [3:0] r, input logic d,
                                 input logic rs);
        req  = r;
        done = d;
        rst  = rs;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    // Safety net in case something stalls the stimulus.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    logic [3:0] sticky_req;
    logic [3:0] rot_expect [0:4];

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        m_valid      = 1'b0;
        req          = 4'b0000;
        done         = 1'b0;
        rst          = 1'b1;

        // Reset values.
        applyStimulus(4'b0000, 1'b0, 1'b1);
        applyStimulus(4'b0000, 1'b0, 1'b1);
        checkOutput("rst_gnt",     {28'd0, gnt},     32'd0);
        checkOutput("rst_busy",    {31'd0, busy},    32'd0);
        checkOutput("rst_gnt_id",  {30'd0, gnt_id},  32'd0);
        checkOutput("rst_timeout", {31'd0, timeout}, 32'd0);

        // Two requesters sharing, done every third grant cycle.
        applyStimulus(4'b0101, 1'b0, 1'b0);
        checkOutput("t1_first", {28'd0, gnt}, 32'b0001);
        applyStimulus(4'b0101, 1'b0, 1'b0);
        applyStimulus(4'b0101, 1'b0, 1'b0);
        applyStimulus(4'b0101, 1'b1, 1'b0);
        checkOutput("t1_second", {28'd0, gnt}, 32'b0100);
        checkOutput("t1_busy",   {31'd0, busy}, 32'd1);
        applyStimulus(4'b0101, 1'b0, 1'b0);
        applyStimulus(4'b0101, 1'b0, 1'b0);
        applyStimulus(4'b0101, 1'b1, 1'b0);
        checkOutput("t1_third", {28'd0, gnt}, 32'b0001);

        // Lone requester hits the hold limit and is re-granted.
        applyStimulus(4'b0000, 1'b0, 1'b1);
        applyStimulus(4'b1000, 1'b0, 1'b0);
        checkOutput("t2_grant", {28'd0, gnt}, 32'b1000);
        for (int i = 0; i < MAX_HOLD - 1; i++) begin
            applyStimulus(4'b1000, 1'b0, 1'b0);
            checkOutput("t2_hold_gnt", {28'd0, gnt},     32'b1000);
            checkOutput("t2_hold_to",  {31'd0, timeout}, 32'd0);
        end
        applyStimulus(4'b1000, 1'b0, 1'b0);
        checkOutput("t2_timeout",  {31'd0, timeout}, 32'd1);
        checkOutput("t2_regrant",  {28'd0, gnt},     32'b1000);
        applyStimulus(4'b1000, 1'b0, 1'b0);
        checkOutput("t2_pulse_end", {31'd0, timeout}, 32'd0);

        // Owner withdraws with no other requests.
        applyStimulus(4'b0000, 1'b0, 1'b1);
        applyStimulus(4'b0010, 1'b0, 1'b0);
        checkOutput("t3_grant", {28'd0, gnt}, 32'b0010);
        applyStimulus(4'b0000, 1'b0, 1'b0);
        checkOutput("t3_busy",    {31'd0, busy},    32'd0);
        checkOutput("t3_gnt",     {28'd0, gnt},     32'd0);
        checkOutput("t3_timeout", {31'd0, timeout}, 32'd0);
        checkOutput("t3_gnt_id",  {30'd0, gnt_id},  32'd1);

        // Everyone requesting, done every cycle: one owner per cycle.
        applyStimulus(4'b0000, 1'b0, 1'b1);
        rot_expect[0] = 4'b0001;
        rot_expect[1] = 4'b0010;
        rot_expect[2] = 4'b0100;
        rot_expect[3] = 4'b1000;
        rot_expect[4] = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(4'b1111, 1'b1, 1'b0);
            checkOutput("t4_rotate", {28'd0, gnt}, {28'd0, rot_expect[i]});
        end

        // done and hold limit on the same edge: no timeout; handoff to 3,
        // then the same situation without requester 3 hands off to 0.
        for (int pass = 0; pass < 2; pass++) begin
            applyStimulus(4'b0000, 1'b0, 1'b1);
            applyStimulus(4'b0100, 1'b0, 1'b0);
            for (int i = 0; i < MAX_HOLD - 1; i++) begin
                applyStimulus(4'b0100, 1'b0, 1'b0);
            end
            applyStimulus(pass == 0 ? 4'b1101 : 4'b0101, 1'b1, 1'b0);
            checkOutput("t5_timeout", {31'd0, timeout}, 32'd0);
            checkOutput("t5_next", {28'd0, gnt},
                        pass == 0 ? 32'b1000 : 32'b0001);
        end

        // Reset in the middle of a grant.
        applyStimulus(4'b0000, 1'b0, 1'b1);
        applyStimulus(4'b0110, 1'b0, 1'b0);
        applyStimulus(4'b0110, 1'b1, 1'b0);
        checkOutput("t6_owner2", {28'd0, gnt}, 32'b0100);
        applyStimulus(4'b0110, 1'b0, 1'b1);
        checkOutput("t6_rst_gnt",  {28'd0, gnt},     32'd0);
        checkOutput("t6_rst_busy", {31'd0, busy},    32'd0);
        checkOutput("t6_rst_to",   {31'd0, timeout}, 32'd0);
        applyStimulus(4'b0110, 1'b0, 1'b0);
        checkOutput("t6_after", {28'd0, gnt}, 32'b0010);

        // Randomized traffic: alternate fully random cycles with stretches
        // of slowly changing requests so the hold limit is also reached.
        sticky_req = 4'b0000;
        for (int blk = 0; blk < 40; blk++) begin
            for (int c = 0; c < 50; c++) begin
                if (blk % 2 == 0) begin
                    sticky_req = 4'($urandom_range(0, 15));
                    applyStimulus(sticky_req, ($urandom_range(0, 3) == 0),
                                  ($urandom_range(0, 99) == 0));
                end else begin
                    if ($urandom_range(0, 15) == 0)
                        sticky_req = 4'($urandom_range(0, 15));
                    applyStimulus(sticky_req, ($urandom_range(0, 19) == 0),
                                  ($urandom_range(0, 199) == 0));
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
